router_1xn: RTL and testbench
=============================

Name: router_1xn

Overview:
- Parametrised 1-to-N packet router; next generation of the fixed 1x3 router top.
- Accepts byte-serial packets (header, payload, parity) on one input port.
- Steers each packet into one of NUM_PORTS output FIFOs and checks parity.
- New over the previous generation:
  - configurable width, depth and port count;
  - idle gaps allowed inside a packet;
  - out-of-range addresses dropped with a flag;
  - first-word-fall-through outputs;
  - per-port timeout flush with an observable pulse.

Parameters:
- DATA_W, 8, byte width of data_in, data_out lanes and parity.
- NUM_PORTS, 3, number of output channels (2..2**ADDR_W).
- FIFO_DEPTH, 16, entries per output FIFO (>=2, any integer).
- TIMEOUT, 30, consecutive unread cycles with vld_out high before a port is flushed.
- ADDR_W (localparam), max(1, clog2(NUM_PORTS)), header address field width.

Ports:
- clock  in  1  rising-edge clock for all state.
- resetn  in  1  synchronous active-low reset.
- data_in  in  DATA_W  input byte.
- pkt_valid  in  1  data_in carries a packet byte this cycle.
- read_enb  in  NUM_PORTS  per-port pop request.
- data_out  out  NUM_PORTS*DATA_W  port i head entry on bits [i*DATA_W +: DATA_W].
- vld_out  out  NUM_PORTS  port i FIFO non-empty.
- busy  out  1  input byte not accepted this cycle.
- err  out  1  parity mismatch on last completed packet.
- drop  out  1  one-cycle pulse: packet discarded (bad address).
- flush  out  NUM_PORTS  one-cycle pulse: port i timed out and was flushed.

Behaviour:
- Reset: synchronous and active-low. While resetn=0 at a clock edge:
  - all FIFOs empty, counters 0, FSM IDLE;
  - vld_out=0, data_out=0, busy=0, err=0, drop=0, flush=0.
- Accept rule: a byte is accepted on an edge where pkt_valid=1 and busy=0. pkt_valid=0 cycles are idle gaps and are legal anywhere, including mid-packet.
- Packet format:
  - header = {len[DATA_W-1:ADDR_W], addr[ADDR_W-1:0]};
  - then len payload bytes (len=0 legal);
  - then 1 parity byte.
- Expected parity = XOR of header and all payload bytes.
- FSM states: IDLE, PAYLOAD, PARITY.
  - IDLE: header accepted -> latch addr, len; parity accumulator = header; go to PAYLOAD if len>0, else PARITY. A new header clears err.
  - PAYLOAD: each accepted byte XORs into the accumulator and decrements the remaining count; on the last byte go to PARITY.
  - PARITY: accepted byte is compared with the accumulator; err registered one cycle later, held until the next header is accepted; go to IDLE.
- Writes:
  - addr<NUM_PORTS: every accepted byte (header, payload, parity) is written to FIFO[addr] on the accept edge, L+2 entries total.
  - addr>=NUM_PORTS: bytes are consumed and not written; drop pulses the cycle after the header edge; parity is still checked.
- busy (combinational) = state != IDLE and FIFO[addr] full and addr valid.
  - No write-through on full: a same-cycle pop does not clear busy.
  - In IDLE busy=0; a header whose target is full is written the next cycle it is non-full. The header holds busy via the same rule after latching.
- FIFO: first-word-fall-through.
  - vld_out[i] = count!=0; data_out lane shows the head entry.
  - read_enb with vld_out high pops on the edge; read_enb while empty is ignored.
  - Simultaneous push and pop when neither full nor empty: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH+1).
  - data_out of an empty port holds its last value; it is 0 after reset.
- Timeout: per-port counter.
  - Increments each cycle vld_out[i]=1 and read_enb[i]=0.
  - Clears on any pop or when the port is empty.
  - When the counter reaches TIMEOUT-1 and the condition persists, the next edge empties FIFO[i] and pulses flush[i]; vld_out[i]=0 on the following cycle.
- Flush during an active packet to port i: remaining bytes of that packet are consumed and discarded (not written). busy is released; parity/err are still evaluated.
- Flush and push on the same edge: flush wins, and the byte is discarded.
- Reset mid-packet: the packet is abandoned; the next accepted byte is treated as a header.

Test Plan:
- NUM_PORTS=3: header 0x0D (len=3, addr=1), payload 0x11,0x22,0x33, parity 0x0D^0x11^0x22^0x33 = 0x0D -> vld_out=3'b010; popping gives 0x0D,0x11,0x22,0x33,0x0D; err=0.
- Same packet with parity byte 0x00 -> err=1 one cycle after the parity edge; err clears on the next accepted header.
- Header addr=3 with NUM_PORTS=3, len=2 -> drop=1 for one cycle; vld_out stays 0; busy never asserts.
- FIFO_DEPTH=4, len=6 to port 0, no reads -> busy=1 after the 4th write; popping one entry lets the next byte in; all 8 bytes arrive in order.
- Port 2 loaded, read_enb[2]=0 for TIMEOUT cycles -> flush[2] pulses once; vld_out[2]=0 next cycle; one pop at cycle TIMEOUT-2 restarts the count.
- Gaps: pkt_valid low for 5 cycles between payload bytes -> identical FIFO contents and err result as a gap-free send.

Source files
------------

// File: rtl/router_1xn.sv
// Parametrised 1-to-N byte-serial packet router with parity check, per-port
// first-word-fall-through FIFOs and per-port timeout flush.
module router_1xn #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned NUM_PORTS  = 3,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned TIMEOUT    = 30
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic [DATA_W-1:0]             data_in,
    input  logic                          pkt_valid,
    input  logic [NUM_PORTS-1:0]          read_enb,
    output logic [NUM_PORTS*DATA_W-1:0]   data_out,
    output logic [NUM_PORTS-1:0]          vld_out,
    output logic                          busy,
    output logic                          err,
    output logic                          drop,
    output logic [NUM_PORTS-1:0]          flush
);

    localparam int unsigned ADDR_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned LEN_W  = DATA_W - ADDR_W;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StPayload, StParity} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   hdr_q, hdr_d;
    logic                tgt_ok_q, tgt_ok_d;
    logic                hdr_pend_q, hdr_pend_d;
    logic                err_q, err_d;
    logic                drop_q, drop_d;
    logic [NUM_PORTS-1:0] flush_q;

    logic [DATA_W-1:0]   mem_q    [NUM_PORTS][FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q [NUM_PORTS];
    logic [PTR_W-1:0]    rd_ptr_q [NUM_PORTS];
    logic [CNT_W-1:0]    count_q  [NUM_PORTS];
    logic [TMO_W-1:0]    tmo_q    [NUM_PORTS];
    logic [DATA_W-1:0]   hold_q   [NUM_PORTS];
    logic [DATA_W-1:0]   head     [NUM_PORTS];

    logic [NUM_PORTS-1:0] full, pop, push, flush_now, hdr_hit, cur_hit;
    logic [ADDR_W-1:0]   hdr_addr, wr_sel;
    logic [LEN_W-1:0]    hdr_len;
    logic [DATA_W-1:0]   wr_data;
    logic                hdr_valid, hdr_full, hdr_flush, cur_full, cur_flush;
    logic                accept, wr_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign hdr_addr = data_in[ADDR_W-1:0];
    assign hdr_len  = data_in[DATA_W-1:ADDR_W];

    always_comb begin
        data_out = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            head[i]      = mem_q[i][rd_ptr_q[i]];
            vld_out[i]   = (count_q[i] != '0);
            full[i]      = (count_q[i] == CNT_W'(FIFO_DEPTH));
            pop[i]       = read_enb[i] && vld_out[i];
            flush_now[i] = vld_out[i] && !read_enb[i] && (tmo_q[i] == TMO_W'(TIMEOUT - 1));
            hdr_hit[i]   = (hdr_addr == ADDR_W'(i));
            cur_hit[i]   = (addr_q == ADDR_W'(i));
            data_out[i*DATA_W +: DATA_W] = vld_out[i] ? head[i] : hold_q[i];
        end
    end

    assign hdr_valid = |hdr_hit;
    assign hdr_full  = |(hdr_hit & full);
    assign hdr_flush = |(hdr_hit & flush_now);
    assign cur_full  = |(cur_hit & full);
    assign cur_flush = |(cur_hit & flush_now);

    // A header still waiting for FIFO space also holds off further bytes.
    assign busy   = (state_q != StIdle) && tgt_ok_q && (cur_full || hdr_pend_q);
    assign accept = pkt_valid && !busy;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        acc_d      = acc_q;
        hdr_d      = hdr_q;
        tgt_ok_d   = tgt_ok_q;
        hdr_pend_d = hdr_pend_q;
        err_d      = err_q;
        drop_d     = 1'b0;
        wr_en      = 1'b0;
        wr_sel     = addr_q;
        wr_data    = data_in;
        if (state_q == StIdle) begin
            if (accept) begin
                addr_d     = hdr_addr;
                len_d      = hdr_len;
                acc_d      = data_in;
                hdr_d      = data_in;
                err_d      = 1'b0;
                drop_d     = !hdr_valid;
                tgt_ok_d   = hdr_valid && !hdr_flush;
                hdr_pend_d = hdr_valid && !hdr_flush && hdr_full;
                wr_en      = hdr_valid && !hdr_flush && !hdr_full;
                wr_sel     = hdr_addr;
                state_d    = (hdr_len == '0) ? StParity : StPayload;
            end
        end else begin
            // A flushed target discards the rest of its packet.
            if (tgt_ok_q && cur_flush) begin
                tgt_ok_d   = 1'b0;
                hdr_pend_d = 1'b0;
            end else if (tgt_ok_q && hdr_pend_q && !cur_full) begin
                wr_en      = 1'b1;
                wr_data    = hdr_q;
                hdr_pend_d = 1'b0;
            end
            if (accept) begin
                if (tgt_ok_q && !cur_flush) wr_en = 1'b1;
                unique case (state_q)
                    StPayload: begin
                        acc_d = acc_q ^ data_in;
                        len_d = len_q - LEN_W'(1);
                        if (len_q == LEN_W'(1)) state_d = StParity;
                    end
                    StParity: begin
                        err_d   = (data_in != acc_q);
                        state_d = StIdle;
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            push[i] = wr_en && (wr_sel == ADDR_W'(i));
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            len_q      <= '0;
            acc_q      <= '0;
            hdr_q      <= '0;
            tgt_ok_q   <= 1'b0;
            hdr_pend_q <= 1'b0;
            err_q      <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            acc_q      <= acc_d;
            hdr_q      <= hdr_d;
            tgt_ok_q   <= tgt_ok_d;
            hdr_pend_q <= hdr_pend_d;
            err_q      <= err_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (push[i]) mem_q[i][wr_ptr_q[i]] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            flush_q <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
                tmo_q[i]    <= '0;
                hold_q[i]   <= '0;
            end
        end else begin
            flush_q <= flush_now;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (vld_out[i]) hold_q[i] <= head[i];
                if (flush_now[i]) begin
                    wr_ptr_q[i] <= '0;
                    rd_ptr_q[i] <= '0;
                    count_q[i]  <= '0;
                    tmo_q[i]    <= '0;
                end else begin
                    if (push[i]) wr_ptr_q[i] <= ptr_inc(wr_ptr_q[i]);
                    if (pop[i])  rd_ptr_q[i] <= ptr_inc(rd_ptr_q[i]);
                    if (push[i] && !pop[i])      count_q[i] <= count_q[i] + CNT_W'(1);
                    else if (pop[i] && !push[i]) count_q[i] <= count_q[i] - CNT_W'(1);
                    if (vld_out[i] && !read_enb[i]) tmo_q[i] <= tmo_q[i] + TMO_W'(1);
                    else                            tmo_q[i] <= '0;
                end
            end
        end
    end

    assign err   = err_q;
    assign drop  = drop_q;
    assign flush = flush_q;

endmodule

// File: tb/tb_router_1xn.sv
// Bench for router_1xn: directed scenarios plus random traffic, every cycle
// compared against a queue-based packet model.
module tb_router_1xn;

    localparam int DW    = 8;
    localparam int NP    = 3;
    localparam int DEPTH = 4;
    localparam int TMO   = 20;

    logic               clock = 1'b0;
    logic               resetn;
    logic [DW-1:0]      data_in;
    logic               pkt_valid;
    logic [NP-1:0]      read_enb;
    logic [NP*DW-1:0]   data_out;
    logic [NP-1:0]      vld_out;
    logic               busy, err, drop;
    logic [NP-1:0]      flush;

    router_1xn #(
        .DATA_W    (DW),
        .NUM_PORTS (NP),
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT   (TMO)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .data_in  (data_in),
        .pkt_valid(pkt_valid),
        .read_enb (read_enb),
        .data_out (data_out),
        .vld_out  (vld_out),
        .busy     (busy),
        .err      (err),
        .drop     (drop),
        .flush    (flush)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: one queue per port plus packet progress counters.
    logic [7:0] mq [NP][$];
    int         tmo_m [NP];
    logic [7:0] last_m [NP];
    bit         in_pkt, tgt_ok, hdr_pend;
    int         tgt, left;
    logic [7:0] hdr_m, acc_m;
    logic       err_m, drop_m;
    logic [NP-1:0] flush_m;

    function automatic void model_reset();
        for (int i = 0; i < NP; i++) begin
            mq[i].delete();
            tmo_m[i]  = 0;
            last_m[i] = 8'h00;
        end
        in_pkt = 0; tgt_ok = 0; hdr_pend = 0; tgt = 0; left = 0;
        hdr_m = 0; acc_m = 0; err_m = 0; drop_m = 0; flush_m = '0;
    endfunction

    function automatic bit m_busy();
        return in_pkt && tgt_ok && (mq[tgt].size() == DEPTH || hdr_pend);
    endfunction

    function automatic logic [NP-1:0] m_vld();
        logic [NP-1:0] v;
        for (int i = 0; i < NP; i++) v[i] = (mq[i].size() > 0);
        return v;
    endfunction

    function automatic logic [NP*DW-1:0] m_data();
        logic [NP*DW-1:0] v;
        for (int i = 0; i < NP; i++) v[i*DW +: DW] = (mq[i].size() > 0) ? mq[i][0] : last_m[i];
        return v;
    endfunction

    function automatic void model_edge(input logic pv, input logic [7:0] din,
                                       input logic [NP-1:0] rd);
        int sz [NP];
        bit fl [NP];
        int push_port = -1;
        logic [7:0] push_byte = 8'h00;
        bit acc_ok = pv && !m_busy();
        for (int i = 0; i < NP; i++) begin
            sz[i] = mq[i].size();
            fl[i] = (sz[i] > 0) && !rd[i] && (tmo_m[i] == TMO - 1);
        end
        drop_m = 0;
        if (in_pkt && tgt_ok) begin
            if (fl[tgt]) begin
                tgt_ok = 0; hdr_pend = 0;
            end else if (hdr_pend && sz[tgt] < DEPTH) begin
                push_port = tgt; push_byte = hdr_m; hdr_pend = 0;
            end
        end
        if (acc_ok) begin
            if (!in_pkt) begin
                int a = int'(din) % 4;
                in_pkt = 1; left = int'(din) / 4 + 1; acc_m = din; err_m = 0;
                tgt = a; drop_m = (a >= NP); tgt_ok = 0; hdr_pend = 0;
                if (a < NP && !fl[a]) begin
                    tgt_ok = 1;
                    if (sz[a] == DEPTH) begin hdr_pend = 1; hdr_m = din; end
                    else begin push_port = a; push_byte = din; end
                end
            end else begin
                if (tgt_ok) begin push_port = tgt; push_byte = din; end
                if (left == 1) begin err_m = (din != acc_m); in_pkt = 0; end
                else begin acc_m ^= din; left--; end
            end
        end
        for (int i = 0; i < NP; i++) begin
            if (sz[i] > 0) last_m[i] = mq[i][0];
            if (fl[i]) mq[i].delete();
            else if (rd[i] && sz[i] > 0) void'(mq[i].pop_front());
            if (fl[i]) tmo_m[i] = 0;
            else if (sz[i] > 0 && !rd[i]) tmo_m[i]++;
            else tmo_m[i] = 0;
            flush_m[i] = fl[i];
        end
        if (push_port >= 0) mq[push_port].push_back(push_byte);
    endfunction

    logic [7:0] popped [NP][$];
    logic [7:0] expq [$];
    logic [7:0] tx [$];
    int drop_cnt, busy_cnt;
    int flush_cnt [NP];
    logic last_busy;

    task automatic step(input logic pv, input logic [7:0] din, input logic [NP-1:0] rd,
                        output bit accepted);
        @(negedge clock);
        pkt_valid = pv; data_in = din; read_enb = rd;
        #1;
        check("busy", 64'(busy), 64'(m_busy()));
        check("vld_out", 64'(vld_out), 64'(m_vld()));
        check("data_out", 64'(data_out), 64'(m_data()));
        check("err", 64'(err), 64'(err_m));
        check("drop", 64'(drop), 64'(drop_m));
        check("flush", 64'(flush), 64'(flush_m));
        for (int i = 0; i < NP; i++) begin
            if (rd[i] && vld_out[i]) popped[i].push_back(data_out[i*DW +: DW]);
            if (flush[i]) flush_cnt[i]++;
        end
        if (drop) drop_cnt++;
        if (busy) busy_cnt++;
        last_busy = busy;
        accepted = pv && !m_busy();
        @(posedge clock);
        model_edge(pv, din, rd);
    endtask

    task automatic idle(input int n, input logic [NP-1:0] rd);
        bit d;
        repeat (n) step(1'b0, 8'($urandom), rd, d);
    endtask

    task automatic send(input int gap, input logic [NP-1:0] rd);
        bit acc;
        int guard = 0;
        while (tx.size() > 0) begin
            step(1'b1, tx[0], rd, acc);
            if (acc) begin
                void'(tx.pop_front());
                guard = 0;
                idle(gap, rd);
            end else if (++guard > 200) begin
                check("send_stall", 64'(guard), 64'(200));
                tx.delete();
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0; pkt_valid = 1'b0; read_enb = '0; data_in = '0;
        @(posedge clock);
        @(posedge clock);
        model_reset();
        #1;
        check("rst_vld", 64'(vld_out), 64'(0));
        check("rst_data", 64'(data_out), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_drop", 64'(drop), 64'(0));
        check("rst_flush", 64'(flush), 64'(0));
        resetn = 1'b1;
    endtask

    task automatic clear_popped();
        for (int i = 0; i < NP; i++) popped[i].delete();
    endtask

    task automatic cmp_popped(input int p, input string tag);
        check({tag, "_len"}, 64'(popped[p].size()), 64'(expq.size()));
        for (int k = 0; k < expq.size() && k < popped[p].size(); k++)
            check(tag, 64'(popped[p][k]), 64'(expq[k]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        logic [NP-1:0] rd;
        logic [7:0] rs [$];
        int stall [NP];
        resetn = 1'b0; pkt_valid = 1'b0; read_enb = '0; data_in = '0;
        do_reset();

        // Good packet to port 1, read as it arrives.
        clear_popped();
        tx = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        expq = tx;
        send(0, 3'b010);
        idle(4, 3'b010);
        cmp_popped(1, "good_pkt");
        check("good_err", 64'(err), 64'(0));

        // Bad parity; err clears on the next header.
        tx = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h00};
        send(0, 3'b010);
        idle(1, 3'b010);
        check("bad_err", 64'(err), 64'(1));
        tx = '{8'h02};
        send(0, 3'b110);
        #2 check("err_clr", 64'(err), 64'(0));
        tx = '{8'h02};
        send(0, 3'b110);
        idle(4, 3'b110);

        // Out-of-range address.
        drop_cnt = 0; busy_cnt = 0;
        tx = '{8'h0B, 8'hAA, 8'hBB, 8'h1A};
        send(0, 3'b000);
        idle(2, 3'b000);
        check("drop_cnt", 64'(drop_cnt), 64'(1));
        check("drop_busy", 64'(busy_cnt), 64'(0));
        check("drop_vld", 64'(vld_out), 64'(0));

        // Backpressure on a full FIFO.
        clear_popped();
        tx = '{8'h18, 8'h01, 8'h02, 8'h03};
        send(0, 3'b000);
        #2 check("full_busy", 64'(busy), 64'(1));
        step(1'b1, 8'h04, 3'b001, acc);
        check("no_write_through", 64'(last_busy), 64'(1));
        step(1'b1, 8'h04, 3'b000, acc);
        check("pop_frees_slot", 64'(last_busy), 64'(0));
        tx = '{8'h05, 8'h06, 8'h1F};
        send(0, 3'b001);
        idle(8, 3'b001);
        expq = '{8'h18, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h1F};
        cmp_popped(0, "full_order");

        // Timeout flush of port 2.
        for (int i = 0; i < NP; i++) flush_cnt[i] = 0;
        tx = '{8'h02, 8'h02};
        send(0, 3'b000);
        idle(TMO + 4, 3'b000);
        check("tmo_flush_cnt", 64'(flush_cnt[2]), 64'(1));
        check("tmo_vld", 64'(vld_out[2]), 64'(0));

        // A single pop restarts the timeout count.
        tx = '{8'h06, 8'h55, 8'h53};
        send(0, 3'b000);
        idle(TMO - 5, 3'b000);
        idle(1, 3'b100);
        for (int i = 0; i < NP; i++) flush_cnt[i] = 0;
        idle(TMO - 2, 3'b000);
        check("tmo_restart", 64'(flush_cnt[2]), 64'(0));
        idle(5, 3'b000);
        check("tmo_after_restart", 64'(flush_cnt[2]), 64'(1));

        // Idle gaps inside a packet.
        clear_popped();
        tx = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        expq = tx;
        send(5, 3'b010);
        idle(4, 3'b010);
        cmp_popped(1, "gap_pkt");
        check("gap_err", 64'(err), 64'(0));

        // Reset in the middle of a packet.
        tx = '{8'h0D, 8'h11};
        send(0, 3'b000);
        do_reset();
        clear_popped();
        tx = '{8'h01, 8'h01};
        expq = tx;
        send(0, 3'b010);
        idle(3, 3'b010);
        cmp_popped(1, "post_reset");

        // Random traffic.
        for (int i = 0; i < NP; i++) stall[i] = 0;
        for (int c = 0; c < 4000; c++) begin
            logic pv;
            logic [7:0] din;
            if (rs.size() == 0 && $urandom_range(0, 3) == 0) begin
                int a = $urandom_range(0, 3);
                int len = $urandom_range(0, 5);
                logic [7:0] h = 8'(len * 4 + a);
                logic [7:0] p = h;
                rs.push_back(h);
                for (int k = 0; k < len; k++) begin
                    logic [7:0] b = 8'($urandom);
                    rs.push_back(b);
                    p ^= b;
                end
                if ($urandom_range(0, 7) == 0) p ^= 8'h5A;
                rs.push_back(p);
            end
            for (int i = 0; i < NP; i++) begin
                if (stall[i] > 0) begin
                    rd[i] = 1'b0;
                    stall[i]--;
                end else begin
                    rd[i] = ($urandom_range(0, 2) == 0);
                    if ($urandom_range(0, 60) == 0) stall[i] = $urandom_range(5, 40);
                end
            end
            pv  = (rs.size() > 0) && ($urandom_range(0, 3) != 0);
            din = pv ? rs[0] : 8'($urandom);
            step(pv, din, rd, acc);
            if (acc) void'(rs.pop_front());
            if ($urandom_range(0, 799) == 0) begin
                do_reset();
                rs.delete();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
